// File: rtl/edge_det_pkg.sv
// ---------------------------------------------------------------------------
// edge_det_pkg
// Shared definitions for the multi-channel edge detector:
//   - edge_mode_e : per-channel detect mode encoding
//   - parameter defaults and legal bounds for NCH, SYNC_STAGES, FILT_LEN
//   - mode_match(): decides whether a completed transition should be reported
// ---------------------------------------------------------------------------
package edge_det_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam int NCH_DEF         = 4;
  localparam int NCH_MIN         = 1;
  localparam int NCH_MAX         = 32;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int FILT_LEN_DEF    = 3;
  localparam int FILT_LEN_MIN    = 1;
  localparam int FILT_LEN_MAX    = 255;

  // Returns 1 when a transition towards new_level is one the mode reports.
  function automatic logic mode_match(input edge_mode_e mode, input logic new_level);
    logic hit;
    case (mode)
      EDGE_OFF:  hit = 1'b0;
      EDGE_RISE: hit = new_level;
      EDGE_FALL: hit = ~new_level;
      EDGE_BOTH: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// ---------------------------------------------------------------------------
// edge_chan
// One detector channel: synchroniser chain, stability filter, edge detect
// and sticky flag.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   data   in   raw asynchronous channel input
//   mode   in   2-bit detect mode (edge_mode_e encoding)
//   clr    in   write-1-to-clear strobe for flag
//   level  out  filtered, synchronised level
//   pulse  out  one-cycle pulse on a reported transition
//   flag   out  sticky transition-seen flag
// ---------------------------------------------------------------------------
module edge_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level,
  output logic       pulse,
  output logic       flag
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);
  // The level is accepted on the edge where the counter would reach
  // FILT_LEN, i.e. when it currently holds FILT_LEN-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   level_r;
  logic                   pulse_r;
  logic                   flag_r;

  logic                   sync_val_s;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   level_nxt_s;
  logic                   pulse_nxt_s;
  logic                   flag_nxt_s;

  assign sync_val_s = sync_r[SYNC_STAGES-1];

  // Filter, edge detect and flag next-state.
  always_comb begin
    cnt_nxt_s   = '0;
    level_nxt_s = level_r;
    pulse_nxt_s = 1'b0;
    flag_nxt_s  = flag_r;
    if (sync_val_s != level_r) begin
      if (cnt_r == CNT_LAST) begin
        level_nxt_s = sync_val_s;
        pulse_nxt_s = mode_match(edge_mode_e'(mode), sync_val_s);
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      // Agreement with the accepted level (or a reversal) drops any credit.
      cnt_nxt_s = '0;
    end
    // A new edge beats a simultaneous clear.
    if (pulse_nxt_s) begin
      flag_nxt_s = 1'b1;
    end else if (clr) begin
      flag_nxt_s = 1'b0;
    end else begin
      flag_nxt_s = flag_r;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r  <= '0;
      cnt_r   <= '0;
      level_r <= 1'b0;
      pulse_r <= 1'b0;
      flag_r  <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], data};
      cnt_r   <= cnt_nxt_s;
      level_r <= level_nxt_s;
      pulse_r <= pulse_nxt_s;
      flag_r  <= flag_nxt_s;
    end
  end

  assign level = level_r;
  assign pulse = pulse_r;
  assign flag  = flag_r;

endmodule

// File: rtl/multi_edge_detector.sv
// ---------------------------------------------------------------------------
// multi_edge_detector
// NCH independent filtered edge detectors with sticky flags and an
// aggregated interrupt.
// Ports:
//   i_CLK    in   clock, rising edge
//   i_RST    in   synchronous active-low reset
//   i_DATA   in   [NCH]    raw asynchronous channel inputs
//   i_MODE   in   [2*NCH]  per-channel mode, bits [2k+1:2k] for channel k
//   i_CLR    in   [NCH]    write-1-to-clear strobes for o_FLAG
//   o_LEVEL  out  [NCH]    filtered, synchronised levels
//   o_PULSE  out  [NCH]    one-cycle edge pulses
//   o_FLAG   out  [NCH]    sticky edge-seen flags
//   o_IRQ    out  1        registered OR of o_FLAG
// ---------------------------------------------------------------------------
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [NCH-1:0]   i_DATA,
  input  logic [2*NCH-1:0] i_MODE,
  input  logic [NCH-1:0]   i_CLR,
  output logic [NCH-1:0]   o_LEVEL,
  output logic [NCH-1:0]   o_PULSE,
  output logic [NCH-1:0]   o_FLAG,
  output logic             o_IRQ
);

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
    ) u_chan (
      .clk   (i_CLK),
      .rst_n (i_RST),
      .data  (i_DATA[k]),
      .mode  (i_MODE[2*k +: 2]),
      .clr   (i_CLR[k]),
      .level (o_LEVEL[k]),
      .pulse (o_PULSE[k]),
      .flag  (o_FLAG[k])
    );
  end

  // Interrupt register: follows the flags one cycle late.
  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      o_IRQ <= 1'b0;
    end else begin
      o_IRQ <= |o_FLAG;
    end
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
module tb_multi_edge_detector;

  logic       clk;
  logic       i_RST;
  logic [3:0] i_DATA;
  logic [7:0] i_MODE;
  logic [3:0] i_CLR;
  logic [3:0] o_LEVEL;
  logic [3:0] o_PULSE;
  logic [3:0] o_FLAG;
  logic       o_IRQ;

  int tests_run    = 0;
  int tests_failed = 0;

  multi_edge_detector #(.NCH(4), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .i_CLK   (clk),
    .i_RST   (i_RST),
    .i_DATA  (i_DATA),
    .i_MODE  (i_MODE),
    .i_CLR   (i_CLR),
    .o_LEVEL (o_LEVEL),
    .o_PULSE (o_PULSE),
    .o_FLAG  (o_FLAG),
    .o_IRQ   (o_IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clear every flag and let o_IRQ settle.
  task automatic clear_all();
    i_CLR = 4'hF;
    tick(1);
    i_CLR = 4'h0;
    tick(2);
  endtask

  task automatic test_reset();
    i_RST = 1'b0; i_DATA = 4'hF; i_MODE = 8'h55; i_CLR = 4'h0;
    tick(3);
    tests_run++;
    if ({o_LEVEL, o_PULSE, o_FLAG, o_IRQ} !== 13'h0000) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h expected %h", {o_LEVEL, o_PULSE, o_FLAG, o_IRQ}, 13'h0000);
    end
    i_RST = 1'b1;
    tick(4);
    tests_run++;
    if ({o_LEVEL, o_PULSE} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_release_edge4: got %h expected %h", {o_LEVEL, o_PULSE}, 8'h00);
    end
    tick(1);
    tests_run++;
    if ({o_LEVEL, o_PULSE, o_FLAG, o_IRQ} !== {4'hF, 4'hF, 4'hF, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_release_edge5: got %h expected %h", {o_LEVEL, o_PULSE, o_FLAG, o_IRQ}, {4'hF, 4'hF, 4'hF, 1'b0});
    end
    tick(1);
    tests_run++;
    if ({o_PULSE, o_FLAG, o_IRQ} !== {4'h0, 4'hF, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_release_edge6: got %h expected %h", {o_PULSE, o_FLAG, o_IRQ}, {4'h0, 4'hF, 1'b1});
    end
    // Return to a quiet all-low state.
    i_MODE = 8'h00; i_DATA = 4'h0;
    tick(8);
    clear_all();
    tests_run++;
    if ({o_LEVEL, o_FLAG, o_IRQ} !== 9'h000) begin
      tests_failed++;
      $display("FAIL reset_settle: got %h expected %h", {o_LEVEL, o_FLAG, o_IRQ}, 9'h000);
    end
  endtask

  task automatic test_rise();
    logic seen;
    i_MODE = 8'h01;
    i_DATA[0] = 1'b1;
    tick(4);
    tests_run++;
    if ({o_LEVEL[0], o_PULSE[0]} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rise_edge4: got %b expected %b", {o_LEVEL[0], o_PULSE[0]}, 2'b00);
    end
    tick(1);
    tests_run++;
    if ({o_LEVEL, o_PULSE} !== 8'h11) begin
      tests_failed++;
      $display("FAIL rise_edge5: got %h expected %h", {o_LEVEL, o_PULSE}, 8'h11);
    end
    tick(1);
    tests_run++;
    if ({o_PULSE[0], o_FLAG[0]} !== 2'b01) begin
      tests_failed++;
      $display("FAIL rise_edge6: got %b expected %b", {o_PULSE[0], o_FLAG[0]}, 2'b01);
    end
    clear_all();
    // Falling edge in rising-only mode: level follows, nothing reported.
    seen = 1'b0;
    i_DATA[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (o_PULSE[0] || o_FLAG[0]) seen = 1'b1;
    end
    tests_run++;
    if ({seen, o_LEVEL[0]} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rise_ignores_fall: got %b expected %b", {seen, o_LEVEL[0]}, 2'b00);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] pat;
    logic       seen;
    // High 2, low 1, high 2: no run reaches three stable cycles.
    pat  = 8'h1B;
    seen = 1'b0;
    i_MODE = 8'h0C;
    for (int i = 0; i < 16; i++) begin
      i_DATA[1] = (i < 8) ? pat[i] : 1'b0;
      tick(1);
      if (o_LEVEL[1] || o_PULSE[1] || o_FLAG[1]) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_filtered: got %b expected %b", seen, 1'b0);
    end
  endtask

  task automatic test_both();
    int npulse;
    int first_e;
    int second_e;
    npulse = 0; first_e = 0; second_e = 0;
    i_MODE = 8'h30;
    for (int e = 1; e <= 25; e++) begin
      i_DATA[2] = (e <= 10);
      tick(1);
      if (o_PULSE[2]) begin
        npulse++;
        if (npulse == 1) first_e = e;
        if (npulse == 2) second_e = e;
      end
    end
    tests_run++;
    if (npulse != 2 || first_e != 5 || second_e != 15) begin
      tests_failed++;
      $display("FAIL both_pulses: got count %0d at %0d,%0d expected count 2 at 5,15", npulse, first_e, second_e);
    end
    tests_run++;
    if ({o_LEVEL[2], o_FLAG[2]} !== 2'b01) begin
      tests_failed++;
      $display("FAIL both_final: got %b expected %b", {o_LEVEL[2], o_FLAG[2]}, 2'b01);
    end
    clear_all();
  endtask

  task automatic test_clr_collision();
    i_MODE = 8'h04;
    i_DATA[1] = 1'b1;
    tick(4);
    i_CLR[1] = 1'b1;
    tick(1);
    i_CLR[1] = 1'b0;
    tests_run++;
    if ({o_PULSE[1], o_FLAG[1], o_IRQ} !== 3'b110) begin
      tests_failed++;
      $display("FAIL clr_set_wins: got %b expected %b", {o_PULSE[1], o_FLAG[1], o_IRQ}, 3'b110);
    end
    tick(1);
    tests_run++;
    if ({o_FLAG[1], o_IRQ} !== 2'b11) begin
      tests_failed++;
      $display("FAIL clr_irq_rise: got %b expected %b", {o_FLAG[1], o_IRQ}, 2'b11);
    end
    i_CLR[1] = 1'b1;
    tick(1);
    i_CLR[1] = 1'b0;
    tests_run++;
    if ({o_FLAG[1], o_IRQ} !== 2'b01) begin
      tests_failed++;
      $display("FAIL clr_flag_cleared: got %b expected %b", {o_FLAG[1], o_IRQ}, 2'b01);
    end
    tick(1);
    tests_run++;
    if ({o_FLAG[1], o_IRQ} !== 2'b00) begin
      tests_failed++;
      $display("FAIL clr_irq_fall: got %b expected %b", {o_FLAG[1], o_IRQ}, 2'b00);
    end
  endtask

  task automatic test_mode_off();
    logic seen;
    seen = 1'b0;
    i_MODE = 8'h00;
    i_DATA[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (o_PULSE[3] || o_FLAG[3] || o_IRQ) seen = 1'b1;
    end
    tests_run++;
    if (o_LEVEL[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL off_level_high: got %b expected %b", o_LEVEL[3], 1'b1);
    end
    i_DATA[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (o_PULSE[3] || o_FLAG[3] || o_IRQ) seen = 1'b1;
    end
    tests_run++;
    if ({o_LEVEL[3], seen} !== 2'b00) begin
      tests_failed++;
      $display("FAIL off_level_low_quiet: got %b expected %b", {o_LEVEL[3], seen}, 2'b00);
    end
  endtask

  task automatic test_back_to_back();
    i_MODE = 8'h00; i_DATA = 4'h0;
    tick(8);
    clear_all();
    i_MODE = 8'hFF;
    i_DATA = 4'b1011;
    tick(5);
    tests_run++;
    if ({o_LEVEL, o_PULSE} !== 8'hBB) begin
      tests_failed++;
      $display("FAIL simult_edge5: got %h expected %h", {o_LEVEL, o_PULSE}, 8'hBB);
    end
    tick(1);
    tests_run++;
    if ({o_PULSE, o_FLAG, o_IRQ} !== {4'h0, 4'hB, 1'b1}) begin
      tests_failed++;
      $display("FAIL simult_edge6: got %h expected %h", {o_PULSE, o_FLAG, o_IRQ}, {4'h0, 4'hB, 1'b1});
    end
  endtask

  task automatic test_reset_midfilter();
    logic seen;
    seen = 1'b0;
    i_DATA = 4'h0;
    tick(3);
    i_RST = 1'b0;
    tick(1);
    tests_run++;
    if ({o_LEVEL, o_PULSE, o_FLAG, o_IRQ} !== 13'h0000) begin
      tests_failed++;
      $display("FAIL midfilter_reset: got %h expected %h", {o_LEVEL, o_PULSE, o_FLAG, o_IRQ}, 13'h0000);
    end
    i_RST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (o_PULSE != 4'h0 || o_LEVEL != 4'h0) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL midfilter_no_pulse: got %b expected %b", seen, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_both();
    test_clr_collision();
    test_mode_off();
    test_back_to_back();
    test_reset_midfilter();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
